led_frame_feeder: RTL and testbench
===================================

Name: led_frame_feeder

Overview:
- Upstream stage of the WS2812 pulse generator: on a frame request, walks the pixel frame buffer (NUM_LEDS*3 bytes, written by the AVR/ArtNet side) and serializes it MSB-first, one bit per generator `read` pulse.
- Drives the generator's `data`, `lastBit` and `start` inputs, consumes its `read` and `finish` outputs, and reports frame completion to the host side.
- Frame buffer is a synchronous RAM read port with 1-cycle latency.

Parameters:
- NUM_LEDS, 60, number of LEDs in the chain; a frame is NUM_LEDS*3 bytes = NUM_LEDS*24 bits.
- ADDR_W, 8, frame buffer address width; must satisfy 2^ADDR_W >= NUM_LEDS*3.

Ports:
- clk  in  1  system clock (20 MHz).
- reset  in  1  asynchronous, active-high reset.
- frame_req  in  1  1-cycle pulse: send the frame buffer once.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  1-cycle pulse when the generator reports the RES period complete.
- mem_addr  out  ADDR_W  frame buffer byte address.
- mem_rd  out  1  read strobe; mem_rdata is valid the cycle after.
- mem_rdata  in  8  frame buffer read data.
- drv_data  out  1  current bit to the generator.
- drv_last_bit  out  1  high while the final bit of the frame is presented.
- drv_start  out  1  1-cycle start pulse to the generator.
- drv_read  in  1  generator's advance-to-next-bit pulse.
- drv_finish  in  1  generator's end-of-RES pulse.
- brightness  in  8  global scale; used only with the optional feature.
- underrun  out  1  sticky error flag: drv_read seen while drv_last_bit is high, or outside SHIFT.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending=0, all counters 0.
- State IDLE: on frame_req, go to FETCH0, set busy=1 and clear underrun.
- State FETCH0: mem_addr=0, mem_rd=1 for one cycle, then go to LOAD0.
- State LOAD0: shift_reg<=mem_rdata, bit_idx=0, byte_idx=0, then go to START.
- State START: drv_start=1 for exactly one cycle; drv_data=shift_reg[7] is already valid. Go to SHIFT. Start-to-first-bit latency from frame_req is 3 cycles.
- Prefetch, in SHIFT: one cycle after any shift_reg load, if byte_idx < NUM_LEDS*3-1, issue mem_rd at byte_idx+1. Capture the result into next_byte the following cycle and set next_valid.
- Advance, in SHIFT: on drv_read, if bit_idx!=7, shift_reg<=shift_reg<<1 and bit_idx++.
  - If bit_idx==7, shift_reg<=next_byte, byte_idx++, bit_idx=0 and next_valid=0.
  - If drv_read arrives with bit_idx==7 and next_valid=0, set underrun and load 0x00 (cannot happen at 25 cycles/bit; it is a checker only).
- drv_data is always shift_reg[7]. It changes only on the cycle after drv_read.
- drv_last_bit = (byte_idx==NUM_LEDS*3-1) && (bit_idx==7), registered with drv_data.
- When drv_last_bit is high, go to WAIT_RES. Any further drv_read sets underrun and is otherwise ignored.
- State WAIT_RES: hold drv_data and drv_last_bit. On drv_finish, pulse frame_done for one cycle.
  - If pending, clear it and go to FETCH0 with busy held at 1.
  - Otherwise go to IDLE with busy=0.
- frame_req while busy sets pending (one deep; additional requests merge). frame_req in the same cycle as drv_finish sets pending, so the frame restarts.
- drv_finish outside WAIT_RES is ignored.
- Counters: byte_idx is ADDR_W bits and bit_idx is 3 bits. mem_addr = byte_idx+1 during prefetch and never exceeds NUM_LEDS*3-1.
- Asynchronous reset mid-frame: return to IDLE immediately, drop pending, outputs 0. No frame_done is generated.

Optional Feature:
- Macro BRIGHTNESS_SCALE_EN.
- Defined: every fetched byte is replaced by (mem_rdata*(brightness+1))>>8 before it enters next_byte or shift_reg. The multiply is registered in the capture stage and adds 1 cycle to fetch latency, so start-to-first-bit latency becomes 4 cycles. brightness=255 gives identity and brightness=0 gives 0. brightness is sampled per byte.
- Undefined: bytes pass unmodified and the brightness port is unused.

Test Plan:
- NUM_LEDS=2, RAM={A5,FF,00,80,01,C3}, one frame_req, behavioural generator model: 48 bits observed equal to 1010_0101 1111_1111 … 1100_0011; drv_start pulses once; drv_last_bit high only during bit 47; frame_done once, after drv_finish.
- mem_rd trace over the same frame: addresses 0,1,2,3,4,5, each exactly once, with no read beyond address 5.
- frame_req pulsed twice mid-frame: exactly one extra frame is sent back-to-back; busy stays 1 across the boundary; 2 frame_done pulses in total.
- Reset asserted at bit 20: all outputs 0 the same cycle; a new frame_req then sends from byte 0 correctly.
- Extra drv_read injected after bit 47, and a spurious drv_finish in SHIFT: underrun=1, data unchanged, frame unaffected; underrun is cleared by the next accepted frame_req.
- BRIGHTNESS_SCALE_EN with brightness=0x7F and RAM byte 0xFF: serialized byte is 0x7F. With brightness=0xFF: 0xFF. With brightness=0x00: 0x00.

Source files
------------

// File: rtl/led_frame_feeder_if.sv
// Frame-buffer read port and WS2812 generator handshake used by led_frame_feeder.
// master = feeder side, slave = frame RAM / pulse generator side.
interface led_frame_feeder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              drv_data;
  logic              drv_last_bit;
  logic              drv_start;
  logic              drv_read;
  logic              drv_finish;

  modport master (
    output mem_addr, mem_rd, drv_data, drv_last_bit, drv_start,
    input  mem_rdata, drv_read, drv_finish
  );

  modport slave (
    input  mem_addr, mem_rd, drv_data, drv_last_bit, drv_start,
    output mem_rdata, drv_read, drv_finish
  );
endinterface

// File: rtl/led_frame_feeder.sv
// Walks the LED frame buffer and serializes it MSB-first into the WS2812 pulse generator.
// Optional BRIGHTNESS_SCALE_EN: scale every fetched byte by (brightness+1)/256, one extra fetch cycle.
module led_frame_feeder #(
  parameter int NUM_LEDS = 60,
  parameter int ADDR_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_req,
  output logic       busy,
  output logic       frame_done,
  input  logic [7:0] brightness,
  output logic       underrun,
  led_frame_feeder_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NUM_LEDS * 3 - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH0, LOAD0, START, SHIFT, WAIT_RES
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        shift_reg;
  logic [7:0]        next_byte;
  logic              next_valid;
  logic [ADDR_W-1:0] byte_idx;
  logic [2:0]        bit_idx;
  logic              pending;
  logic              prefetch_req;
  logic              rd_q;
  logic              fetch_valid;
  logic [7:0]        fetch_data;
  logic              at_last;
  logic              in_stream;

  assign at_last   = (byte_idx == LAST_BYTE) && (bit_idx == 3'd7);
  assign in_stream = (state == START) || (state == SHIFT);

`ifdef BRIGHTNESS_SCALE_EN
  // Scaled byte is registered, so fetch results arrive two cycles after mem_rd.
  logic        sc_valid;
  logic [7:0]  sc_data;
  logic [8:0]  gain;
  logic [15:0] product;

  assign gain    = {1'b0, brightness} + 9'd1;
  assign product = 16'(bus.mem_rdata) * 16'(gain);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_valid <= 1'b0;
      sc_data  <= 8'h00;
    end else begin
      sc_valid <= rd_q;
      if (rd_q) sc_data <= 8'(product >> 8);
    end
  end

  assign fetch_valid = sc_valid;
  assign fetch_data  = sc_data;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign fetch_valid       = rd_q;
  assign fetch_data        = bus.mem_rdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_nx = state;
    unique case (state)
      IDLE:     if (frame_req) state_nx = FETCH0;
      FETCH0:   state_nx = LOAD0;
      LOAD0:    if (fetch_valid) state_nx = START;
      START:    state_nx = SHIFT;
      SHIFT:    if (at_last) state_nx = WAIT_RES;
      WAIT_RES: if (bus.drv_finish) state_nx = (pending || frame_req) ? FETCH0 : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != IDLE);
    frame_done       = (state == WAIT_RES) && bus.drv_finish;
    bus.drv_start    = (state == START);
    bus.drv_data     = shift_reg[7];
    bus.drv_last_bit = at_last && ((state == SHIFT) || (state == WAIT_RES));
    bus.mem_rd       = 1'b0;
    bus.mem_addr     = '0;
    if (state == FETCH0) begin
      bus.mem_rd = 1'b1;
    end else if (prefetch_req && in_stream && (byte_idx < LAST_BYTE)) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = byte_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= 8'h00;
      next_byte    <= 8'h00;
      next_valid   <= 1'b0;
      byte_idx     <= '0;
      bit_idx      <= 3'd0;
      pending      <= 1'b0;
      underrun     <= 1'b0;
      prefetch_req <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      rd_q         <= bus.mem_rd;
      prefetch_req <= 1'b0;

      // One-deep request queue; a request coinciding with drv_finish restarts directly.
      if ((state == IDLE) || ((state == WAIT_RES) && bus.drv_finish)) pending <= 1'b0;
      else if (frame_req)                                               pending <= 1'b1;

      if ((state == IDLE) && frame_req)
        underrun <= 1'b0;
      else if (bus.drv_read && ((state != SHIFT) || at_last))
        underrun <= 1'b1;
      else if ((state == SHIFT) && bus.drv_read && (bit_idx == 3'd7) && !next_valid)
        underrun <= 1'b1;

      if ((state == LOAD0) && fetch_valid) begin
        shift_reg    <= fetch_data;
        byte_idx     <= '0;
        bit_idx      <= 3'd0;
        next_valid   <= 1'b0;
        prefetch_req <= 1'b1;
      end

      if ((state == SHIFT) && bus.drv_read && !at_last) begin
        if (bit_idx != 3'd7) begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_idx   <= bit_idx + 3'd1;
        end else begin
          shift_reg    <= next_valid ? next_byte : 8'h00;
          byte_idx     <= byte_idx + ADDR_W'(1);
          bit_idx      <= 3'd0;
          next_valid   <= 1'b0;
          prefetch_req <= 1'b1;
        end
      end

      // Placed after the advance so a same-cycle capture is not lost.
      if (fetch_valid && in_stream) begin
        next_byte  <= fetch_data;
        next_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_feeder.sv
// Directed bench for led_frame_feeder: NUM_LEDS=2 frame buffer and a behavioural WS2812 generator.
module tb_led_frame_feeder;
  localparam int NUM_LEDS = 2;
  localparam int ADDR_W   = 8;
  localparam int BIT_CYC  = 6;
  localparam int RES_CYC  = 12;
  localparam int RX_MAX   = 256;
`ifdef BRIGHTNESS_SCALE_EN
  localparam int START_LAT = 4;
`else
  localparam int START_LAT = 3;
`endif
  localparam logic [47:0] EXP_FRAME = 48'hA5FF_0080_01C3;
  localparam logic [47:0] EXP_LAST  = 48'h0000_0000_0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_req = 1'b0;
  logic [7:0] brightness = 8'hFF;
  logic       busy, frame_done, underrun;

  led_frame_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  led_frame_feeder #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_req  (frame_req),
    .busy       (busy),
    .frame_done (frame_done),
    .brightness (brightness),
    .underrun   (underrun),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:255];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

  logic rx_bits [0:RX_MAX-1];
  logic rx_last [0:RX_MAX-1];
  int   rx_cnt = 0;
  int   cnt_start = 0;
  int   cnt_done = 0;
  int   done_bad = 0;
  int   rd_addr[$];
  bit   gen_abort, gen_done;

  always @(negedge clk) begin
    if (bus.drv_start === 1'b1) cnt_start++;
    if (frame_done === 1'b1) begin
      cnt_done++;
      if (bus.drv_finish !== 1'b1) done_bad++;
    end
    if (bus.mem_rd === 1'b1) rd_addr.push_back(int'(bus.mem_addr));
  end

  // Generator model: presents each bit for BIT_CYC cycles, pulses read, then RES and finish.
  initial begin
    bus.drv_read   = 1'b0;
    bus.drv_finish = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset && bus.drv_start === 1'b1) begin
        gen_abort = 1'b0;
        gen_done  = 1'b0;
        while (!gen_done && !gen_abort) begin
          for (int k = 0; k < BIT_CYC - 1; k++) begin
            @(posedge clk); #1;
            if (reset) gen_abort = 1'b1;
          end
          if (!gen_abort) begin
            if (rx_cnt < RX_MAX) begin
              rx_bits[rx_cnt] = bus.drv_data;
              rx_last[rx_cnt] = bus.drv_last_bit;
            end
            rx_cnt++;
            if (bus.drv_last_bit === 1'b1 || rx_cnt >= RX_MAX) begin
              for (int k = 0; k < RES_CYC; k++) begin
                @(posedge clk); #1;
                if (reset) gen_abort = 1'b1;
              end
              if (!gen_abort) begin
                bus.drv_finish = 1'b1;
                @(posedge clk); #1;
                bus.drv_finish = 1'b0;
              end
              gen_done = 1'b1;
            end else begin
              bus.drv_read = 1'b1;
              @(posedge clk); #1;
              bus.drv_read = 1'b0;
              if (reset) gen_abort = 1'b1;
            end
          end
        end
        bus.drv_read   = 1'b0;
        bus.drv_finish = 1'b0;
      end
    end
  end

  function automatic logic [47:0] got_frame(input int base);
    logic [47:0] v = '0;
    for (int i = 0; i < 48; i++) v = {v[46:0], rx_bits[base + i]};
    return v;
  endfunction

  function automatic logic [47:0] got_last(input int base);
    logic [47:0] v = '0;
    for (int i = 0; i < 48; i++) v = {v[46:0], rx_last[base + i]};
    return v;
  endfunction

  task automatic clear_logs();
    rx_cnt = 0; cnt_start = 0; cnt_done = 0; done_bad = 0;
    rd_addr.delete();
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit timeout);
    int guard = 0;
    while (cnt_done < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    timeout = (cnt_done < n);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, output bit timeout);
    int guard = 0;
    while (rx_cnt < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    timeout = (rx_cnt < n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, underrun, bus.mem_rd, bus.drv_data, bus.drv_last_bit, bus.drv_start} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {busy, frame_done, underrun, bus.mem_rd, bus.drv_data, bus.drv_last_bit, bus.drv_start});
    end
    n_checks++;
    if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h, expected 00", bus.mem_addr); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    bit to;
    int lat = 0;
    logic [47:0] rd_vec = '0;
    clear_logs();
    pulse_req();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.drv_start === 1'b1 && lat == 0) lat = i;
    end
    n_checks++;
    if (lat != START_LAT) begin n_fail++; $display("FAIL start_latency: got %0d, expected %0d", lat, START_LAT); end
    wait_frames(1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got timeout=1, expected 0"); end
    n_checks++;
    if (rx_cnt != 48) begin n_fail++; $display("FAIL single_bitcount: got %0d, expected 48", rx_cnt); end
    n_checks++;
    if (got_frame(0) !== EXP_FRAME) begin n_fail++; $display("FAIL single_data: got %h, expected %h", got_frame(0), EXP_FRAME); end
    n_checks++;
    if (got_last(0) !== EXP_LAST) begin n_fail++; $display("FAIL single_lastbit: got %h, expected %h", got_last(0), EXP_LAST); end
    n_checks++;
    if (cnt_start != 1) begin n_fail++; $display("FAIL single_starts: got %0d, expected 1", cnt_start); end
    n_checks++;
    if (cnt_done != 1 || done_bad != 0) begin
      n_fail++; $display("FAIL single_done: got %0d (%0d unaligned), expected 1 (0)", cnt_done, done_bad);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
    for (int i = 0; i < rd_addr.size() && i < 6; i++) rd_vec = {rd_vec[39:0], 8'(rd_addr[i])};
    n_checks++;
    if (rd_addr.size() != 6 || rd_vec !== 48'h00_01_02_03_04_05) begin
      n_fail++; $display("FAIL mem_trace: got %0d reads %h, expected 6 reads 000102030405", rd_addr.size(), rd_vec);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int busy_drop = 0;
    int guard = 0;
    clear_logs();
    pulse_req();
    wait_rx(20, to);
    pulse_req();
    repeat (10) @(negedge clk);
    pulse_req();
    while (cnt_done < 2 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (cnt_done < 2 && busy !== 1'b1) busy_drop++;
    end
    n_checks++;
    if (to || cnt_done < 2) begin n_fail++; $display("FAIL b2b_timeout: got done=%0d, expected 2", cnt_done); end
    repeat (400) @(negedge clk);
    n_checks++;
    if (cnt_done != 2 || cnt_start != 2) begin
      n_fail++; $display("FAIL b2b_counts: got done=%0d start=%0d, expected 2/2", cnt_done, cnt_start);
    end
    n_checks++;
    if (rx_cnt != 96) begin n_fail++; $display("FAIL b2b_bitcount: got %0d, expected 96", rx_cnt); end
    n_checks++;
    if (got_frame(0) !== EXP_FRAME || got_frame(48) !== EXP_FRAME) begin
      n_fail++; $display("FAIL b2b_data: got %h/%h, expected %h", got_frame(0), got_frame(48), EXP_FRAME);
    end
    n_checks++;
    if (busy_drop != 0) begin n_fail++; $display("FAIL b2b_busy: got %0d idle cycles, expected 0", busy_drop); end
    n_checks++;
    if (rd_addr.size() != 12) begin n_fail++; $display("FAIL b2b_reads: got %0d, expected 12", rd_addr.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    clear_logs();
    pulse_req();
    wait_rx(10, to);
    pulse_req();
    wait_rx(20, to);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, frame_done, underrun, bus.mem_rd, bus.drv_data, bus.drv_last_bit, bus.drv_start, bus.mem_addr} !== 15'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b data=%b rd=%b addr=%h, expected all 0",
               busy, bus.drv_data, bus.mem_rd, bus.mem_addr);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++;
    if (cnt_done != 0 || cnt_start != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got done=%0d start=%0d busy=%b, expected 0/1/0", cnt_done, cnt_start, busy);
    end
    clear_logs();
    pulse_req();
    wait_frames(1, to);
    n_checks++;
    if (to || got_frame(0) !== EXP_FRAME || cnt_done != 1) begin
      n_fail++; $display("FAIL midreset_resend: got %h done=%0d, expected %h done=1", got_frame(0), cnt_done, EXP_FRAME);
    end
  endtask

  task automatic test_underrun();
    bit to;
    logic hold_data;
    clear_logs();
    pulse_req();
    wait_rx(10, to);
    @(posedge clk); #1 bus.drv_finish = 1'b1;
    @(posedge clk); #1 bus.drv_finish = 1'b0;
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b0 || cnt_done != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL spurious_finish: got underrun=%b done=%0d busy=%b, expected 0/0/1", underrun, cnt_done, busy);
    end
    wait_rx(48, to);
    @(posedge clk); #1;
    hold_data = bus.drv_data;
    bus.drv_read = 1'b1;
    @(posedge clk); #1 bus.drv_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL extra_read_flag: got %b, expected 1", underrun); end
    n_checks++;
    if (bus.drv_data !== hold_data || bus.drv_last_bit !== 1'b1) begin
      n_fail++; $display("FAIL extra_read_hold: got data=%b last=%b, expected %b/1", bus.drv_data, bus.drv_last_bit, hold_data);
    end
    wait_frames(1, to);
    n_checks++;
    if (to || got_frame(0) !== EXP_FRAME || cnt_done != 1) begin
      n_fail++; $display("FAIL underrun_frame: got %h done=%0d, expected %h done=1", got_frame(0), cnt_done, EXP_FRAME);
    end
    n_checks++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b, expected 1", underrun); end
    clear_logs();
    pulse_req();
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b, expected 0", underrun); end
    wait_frames(1, to);
  endtask

`ifdef BRIGHTNESS_SCALE_EN
  task automatic test_brightness();
    bit to;
    logic [47:0] f;
    ram[0] = 8'hFF;
    brightness = 8'h7F;
    clear_logs();
    pulse_req();
    wait_frames(1, to);
    f = got_frame(0);
    n_checks++;
    if (to || f[47:40] !== 8'h7F || f[7:0] !== 8'h61) begin
      n_fail++; $display("FAIL bright_7f: got %h/%h, expected 7f/61", f[47:40], f[7:0]);
    end
    brightness = 8'hFF;
    clear_logs();
    pulse_req();
    wait_frames(1, to);
    f = got_frame(0);
    n_checks++;
    if (to || f[47:40] !== 8'hFF) begin n_fail++; $display("FAIL bright_ff: got %h, expected ff", f[47:40]); end
    brightness = 8'h00;
    clear_logs();
    pulse_req();
    wait_frames(1, to);
    f = got_frame(0);
    n_checks++;
    if (to || f !== 48'h0) begin n_fail++; $display("FAIL bright_00: got %h, expected 0", f); end
    brightness = 8'hFF;
    ram[0] = 8'hA5;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'hEE;
    ram[0] = 8'hA5; ram[1] = 8'hFF; ram[2] = 8'h00;
    ram[3] = 8'h80; ram[4] = 8'h01; ram[5] = 8'hC3;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_underrun();
`ifdef BRIGHTNESS_SCALE_EN
    test_brightness();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
